// File: rtl/fg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fg_pkg
// Brief    : Shared defaults and width helper for the foreground classifier.
// Revision : 1.0 - initial release
// ============================================================================
package fg_pkg;

  localparam int PX_W_DEF     = 8;
  localparam int NCH_DEF      = 3;
  localparam int CNT_W_DEF    = 20;
  localparam int ALPHA_SH_DEF = 3;

  // Sum of NCH values of PX_W bits each cannot overflow this width.
  function automatic int calc_diff_w(input int px_w, input int nch);
    return px_w + $clog2(nch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/px_absdiff.sv
`default_nettype none
// ============================================================================
// Module   : px_absdiff
// Brief    : Unsigned absolute difference of two PX_W-bit channel values.
// Revision : 1.0 - initial release
// ============================================================================
module px_absdiff #(
  parameter int PX_W = 8
) (
  input  logic [PX_W-1:0] a,
  input  logic [PX_W-1:0] b,
  output logic [PX_W-1:0] d
);

  always_comb begin
    d = (a >= b) ? (a - b) : (b - a);
  end

endmodule
`default_nettype wire

// File: rtl/fg_classify_stream.sv
`default_nettype none
// ============================================================================
// Module   : fg_classify_stream
// Brief    : Two-stage streaming foreground classifier with per-frame count.
//            Optional background update output enabled by FG_BG_UPDATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fg_classify_stream
  import fg_pkg::*;
#(
  parameter  int PX_W     = PX_W_DEF,
  parameter  int NCH      = NCH_DEF,
  parameter  int CNT_W    = CNT_W_DEF,
  parameter  int ALPHA_SH = ALPHA_SH_DEF,
  localparam int DIFF_W   = calc_diff_w(PX_W, NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*PX_W-1:0]   in_img,
  input  logic [NCH*PX_W-1:0]   in_bg,
  input  logic                  in_sof,
  input  logic                  in_eof,
  input  logic [DIFF_W-1:0]     threshold,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PX_W-1:0]       out_bin,
  output logic                  out_fg,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic [CNT_W-1:0]      fg_count,
  output logic                  count_valid
`ifdef FG_BG_UPDATE_EN
  ,
  output logic [NCH*PX_W-1:0]   bg_upd
`endif
);

  logic adv, in_fire, out_fire;
  logic [NCH-1:0][PX_W-1:0] absd;

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_ch
      px_absdiff #(.PX_W(PX_W)) u_absdiff (
        .a(in_img[g*PX_W +: PX_W]),
        .b(in_bg[g*PX_W +: PX_W]),
        .d(absd[g])
      );
    end
  endgenerate

  logic                     s1_valid_q, s1_valid_d;
  logic [NCH-1:0][PX_W-1:0] s1_absd_q, s1_absd_d;
  logic                     s1_sof_q, s1_sof_d, s1_eof_q, s1_eof_d;
  logic [DIFF_W-1:0]        s1_thr_q, s1_thr_d, thr_q, thr_d;
  logic                     out_valid_q, out_valid_d;
  logic [PX_W-1:0]          out_bin_q, out_bin_d;
  logic                     out_fg_q, out_fg_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
  logic [CNT_W-1:0]         acc_q, acc_d, acc_next, fg_count_q, fg_count_d;
  logic                     count_valid_q, count_valid_d;
  logic [DIFF_W-1:0]        diff_sum;
  logic                     fg;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign in_fire  = in_valid && adv;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    diff_sum = '0;
    for (int c = 0; c < NCH; c++) begin
      diff_sum = diff_sum + DIFF_W'(s1_absd_q[c]);
    end
    fg = s1_valid_q && (diff_sum >= s1_thr_q);
  end

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_absd_d     = s1_absd_q;
    s1_sof_d      = s1_sof_q;
    s1_eof_d      = s1_eof_q;
    s1_thr_d      = s1_thr_q;
    thr_d         = thr_q;
    out_valid_d   = out_valid_q;
    out_bin_d     = out_bin_q;
    out_fg_d      = out_fg_q;
    out_sof_d     = out_sof_q;
    out_eof_d     = out_eof_q;
    acc_d         = acc_q;
    acc_next      = acc_q;
    fg_count_d    = fg_count_q;
    count_valid_d = 1'b0;

    if (in_fire && in_sof) thr_d = threshold;

    // Each pixel carries its own threshold so a later sof cannot retune it in flight.
    if (adv) begin
      s1_valid_d  = in_valid;
      s1_absd_d   = absd;
      s1_sof_d    = in_sof;
      s1_eof_d    = in_eof;
      s1_thr_d    = in_sof ? threshold : thr_q;
      out_valid_d = s1_valid_q;
      out_fg_d    = fg;
      out_bin_d   = {PX_W{fg}};
      out_sof_d   = s1_valid_q && s1_sof_q;
      out_eof_d   = s1_valid_q && s1_eof_q;
    end

    if (out_fire) begin
      if (out_sof_q) begin
        acc_next = CNT_W'(out_fg_q);
      end else if (acc_q != {CNT_W{1'b1}}) begin
        acc_next = acc_q + CNT_W'(out_fg_q);
      end
      if (out_eof_q) begin
        fg_count_d    = acc_next;
        count_valid_d = 1'b1;
        acc_d         = '0;
      end else begin
        acc_d = acc_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_absd_q     <= '0;
      s1_sof_q      <= 1'b0;
      s1_eof_q      <= 1'b0;
      s1_thr_q      <= '0;
      thr_q         <= '0;
      out_valid_q   <= 1'b0;
      out_bin_q     <= '0;
      out_fg_q      <= 1'b0;
      out_sof_q     <= 1'b0;
      out_eof_q     <= 1'b0;
      acc_q         <= '0;
      fg_count_q    <= '0;
      count_valid_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_absd_q     <= s1_absd_d;
      s1_sof_q      <= s1_sof_d;
      s1_eof_q      <= s1_eof_d;
      s1_thr_q      <= s1_thr_d;
      thr_q         <= thr_d;
      out_valid_q   <= out_valid_d;
      out_bin_q     <= out_bin_d;
      out_fg_q      <= out_fg_d;
      out_sof_q     <= out_sof_d;
      out_eof_q     <= out_eof_d;
      acc_q         <= acc_d;
      fg_count_q    <= fg_count_d;
      count_valid_q <= count_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_bin     = out_bin_q;
  assign out_fg      = out_fg_q;
  assign out_sof     = out_sof_q;
  assign out_eof     = out_eof_q;
  assign fg_count    = fg_count_q;
  assign count_valid = count_valid_q;

`ifdef FG_BG_UPDATE_EN
  logic [NCH*PX_W-1:0] s1_img_q, s1_img_d, s1_bg_q, s1_bg_d;
  logic [NCH*PX_W-1:0] bg_upd_q, bg_upd_d, bg_next;

  // Arithmetic shift keeps the blend between bg and img, so truncation is safe.
  always_comb begin : p_bg_next
    logic signed [PX_W+1:0] img_s, bg_s;
    img_s   = '0;
    bg_s    = '0;
    bg_next = s1_bg_q;
    for (int c = 0; c < NCH; c++) begin
      img_s = $signed({2'b00, s1_img_q[c*PX_W +: PX_W]});
      bg_s  = $signed({2'b00, s1_bg_q[c*PX_W +: PX_W]});
      if (!fg) bg_next[c*PX_W +: PX_W] = PX_W'(bg_s + ((img_s - bg_s) >>> ALPHA_SH));
    end
  end

  always_comb begin
    s1_img_d = s1_img_q;
    s1_bg_d  = s1_bg_q;
    bg_upd_d = bg_upd_q;
    if (adv) begin
      s1_img_d = in_img;
      s1_bg_d  = in_bg;
      bg_upd_d = bg_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_img_q <= '0;
      s1_bg_q  <= '0;
      bg_upd_q <= '0;
    end else begin
      s1_img_q <= s1_img_d;
      s1_bg_q  <= s1_bg_d;
      bg_upd_q <= bg_upd_d;
    end
  end

  assign bg_upd = bg_upd_q;
`else
  logic unused_alpha;
  assign unused_alpha = (ALPHA_SH != 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fg_classify_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fg_classify_stream
// Brief    : Directed self-checking bench for fg_classify_stream (default and
//            CNT_W=2 instances side by side).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fg_classify_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0, out_ready = 1'b1;
  logic [23:0] in_img = '0, in_bg = '0;
  logic [9:0]  threshold = '0;

  logic        in_ready, out_valid, out_fg, out_sof, out_eof, count_valid;
  logic [7:0]  out_bin;
  logic [19:0] fg_count;
  logic        s_in_ready, s_out_valid, s_out_fg, s_out_sof, s_out_eof, s_count_valid;
  logic [7:0]  s_out_bin;
  logic [1:0]  s_fg_count;
`ifdef FG_BG_UPDATE_EN
  logic [23:0] bg_upd, s_bg_upd;
`endif

  always #5 clk = ~clk;

  fg_classify_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_img(in_img), .in_bg(in_bg), .in_sof(in_sof), .in_eof(in_eof),
    .threshold(threshold), .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_fg(out_fg), .out_sof(out_sof), .out_eof(out_eof),
    .fg_count(fg_count), .count_valid(count_valid)
`ifdef FG_BG_UPDATE_EN
    , .bg_upd(bg_upd)
`endif
  );

  fg_classify_stream #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_img(in_img), .in_bg(in_bg), .in_sof(in_sof), .in_eof(in_eof),
    .threshold(threshold), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_bin(s_out_bin), .out_fg(s_out_fg), .out_sof(s_out_sof), .out_eof(s_out_eof),
    .fg_count(s_fg_count), .count_valid(s_count_valid)
`ifdef FG_BG_UPDATE_EN
    , .bg_upd(s_bg_upd)
`endif
  );

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Output/count monitor, sampled on the falling edge.
  int          cyc = 0, pulses = 0, eof_cyc = -100, pulse_cyc = -50;
  logic [19:0] last_cnt = '0;
  logic [1:0]  last_cnt_s = '0;
  logic [10:0] outq[$];
  logic        sat_diverge = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (out_valid && out_ready) begin
      outq.push_back({out_bin, out_fg, out_sof, out_eof});
      if (out_eof) eof_cyc = cyc;
    end
    if (count_valid) begin
      pulses++;
      pulse_cyc  = cyc;
      last_cnt   = fg_count;
      last_cnt_s = s_fg_count;
    end
    if ({s_in_ready, s_out_valid, s_out_bin, s_out_fg, s_out_sof, s_out_eof, s_count_valid} !==
        {in_ready, out_valid, out_bin, out_fg, out_sof, out_eof, count_valid})
      sat_diverge = 1'b1;
  end

  function automatic logic [23:0] pk(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    return {c2, c1, c0};
  endfunction

  task automatic clr();
    outq.delete();
    pulses    = 0;
    eof_cyc   = -100;
    pulse_cyc = -50;
  endtask

  task automatic send(input logic [23:0] img, input logic [23:0] bg, input logic sof,
                      input logic eof, input logic [9:0] thr);
    int   n;
    logic ok;
    in_valid = 1'b1; in_img = img; in_bg = bg; in_sof = sof; in_eof = eof; threshold = thr;
    n = 0; ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check("send_timeout", ok, 1);
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
  endtask

  // Pixel i is foreground (diff 30) when pat[i] is set, otherwise diff 0.
  task automatic send_frame(input int n, input logic [15:0] pat, input logic [9:0] thr, input logic sof0);
    for (int i = 0; i < n; i++)
      send(pk(100, 100, 100), pat[i] ? pk(90, 90, 90) : pk(100, 100, 100),
           (i == 0) && sof0, i == n - 1, thr);
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int n, input logic [15:0] pat, input logic sof0,
                             input logic [19:0] cnt, input logic [1:0] cnt_s);
    logic [10:0] e;
    check({tag, "_len"}, outq.size(), n);
    for (int i = 0; i < n && i < outq.size(); i++) begin
      e = {pat[i] ? 8'hFF : 8'h00, pat[i], (i == 0) && sof0, i == n - 1};
      check($sformatf("%s_px%0d", tag, i), outq[i], e);
    end
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_count"}, last_cnt, cnt);
    check({tag, "_count_sat"}, last_cnt_s, cnt_s);
    check({tag, "_pulse_lag"}, pulse_cyc - eof_cyc, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bin", out_bin, 0);
    check("rst_fg_count", fg_count, 0);
    check("rst_count_valid", count_valid, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Exact threshold hit and latency of two cycles.
    clr();
    send(pk(100, 100, 100), pk(90, 90, 90), 1, 1, 30);
    @(negedge clk);
    check("lat_s1_only", out_valid, 0);
    @(negedge clk);
    check("lat_valid", out_valid, 1);
    check("lat_bin", out_bin, 8'hFF);
    check("lat_fg", out_fg, 1);
    drain();
    check("t1_pulses", pulses, 1);
    check("t1_count", last_cnt, 1);

    // One below threshold.
    clr();
    send(pk(100, 100, 100), pk(91, 90, 90), 1, 1, 30);
    drain();
    check_frame("t2", 1, 16'h0000, 1, 0, 0);

    // 10-pixel frame, 4 foreground.
    clr();
    send_frame(10, 16'h0232, 30, 1);
    drain();
    check_frame("t3", 10, 16'h0232, 1, 4, 3);

    // Backpressure for 3 cycles mid-stream; output holds pixel 1.
    clr();
    fork
      send_frame(6, 16'h000B, 30, 1);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("t4_hold", {out_valid, out_bin, out_fg, out_sof, out_eof}, {1'b1, 8'hFF, 1'b1, 1'b0, 1'b0});
          check("t4_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check_frame("t4", 6, 16'h000B, 1, 3, 3);

    // Threshold change mid-frame takes effect at the next sof.
    clr();
    send(pk(100, 100, 100), pk(90, 90, 90), 1, 0, 30);
    send(pk(100, 100, 100), pk(90, 90, 90), 0, 0, 200);
    send(pk(100, 100, 100), pk(66, 67, 67), 0, 1, 200);
    drain();
    check_frame("t5a", 3, 16'h0007, 1, 3, 3);
    clr();
    send(pk(100, 100, 100), pk(66, 67, 67), 1, 0, 200);
    send(pk(170, 170, 170), pk(100, 100, 100), 0, 0, 30);
    send(pk(100, 100, 100), pk(66, 67, 67), 0, 1, 30);
    drain();
    check_frame("t5b", 3, 16'h0002, 1, 1, 1);

    // Saturation in the CNT_W=2 instance.
    clr();
    send_frame(5, 16'h001F, 30, 1);
    drain();
    check_frame("t6", 5, 16'h001F, 1, 5, 3);

    // Reset mid-frame with pixels in flight.
    send(pk(100, 100, 100), pk(90, 90, 90), 1, 0, 30);
    send(pk(100, 100, 100), pk(90, 90, 90), 0, 0, 30);
    #2 rst = 1'b1;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_outs", {out_bin, out_fg, out_sof, out_eof}, 0);
    check("mrst_fg_count", fg_count, 0);
    check("mrst_fg_count_sat", s_fg_count, 0);
    check("mrst_count_valid", count_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clr();
    // No sof after reset: threshold is 0, so both pixels are foreground.
    send_frame(2, 16'h0001, 30, 0);
    drain();
    check_frame("t6r", 2, 16'h0003, 0, 2, 2);

`ifdef FG_BG_UPDATE_EN
    clr();
    send(pk(80, 80, 80), pk(160, 160, 160), 1, 1, 300);
    @(negedge clk); @(negedge clk);
    check("bgu_bg_fg", out_fg, 0);
    check("bgu_bg_val", bg_upd, pk(150, 150, 150));
    drain();
    send(pk(200, 80, 160), pk(100, 160, 160), 1, 1, 1000);
    @(negedge clk); @(negedge clk);
    check("bgu_mix_val", bg_upd, pk(112, 150, 160));
    drain();
    send(pk(80, 80, 80), pk(160, 160, 160), 1, 1, 30);
    @(negedge clk); @(negedge clk);
    check("bgu_fg_fg", out_fg, 1);
    check("bgu_fg_val", bg_upd, pk(160, 160, 160));
    drain();
`endif

    check("sat_inst_match", sat_diverge, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fg_classify_stream.md
FG_CLASSIFY_STREAM -- requirements
Module: fg_classify_stream

Interface
REQ-001 SHALL have parameter PX_W, default 8, bits per colour channel.
REQ-002 SHALL have parameter NCH, default 3, channels per pixel (1..4).
REQ-003 SHALL have parameter CNT_W, default 20, width of the per-frame foreground counter.
REQ-004 SHALL have parameter ALPHA_SH, default 3, background-update shift (used only with FG_BG_UPDATE_EN).
REQ-005 SHALL derive DIFF_W = PX_W + clog2(NCH) as the width of the summed difference.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst  in  1  reset; asynchronous, active-high.
REQ-008 in_valid  in  1  input pixel valid.
REQ-009 in_ready  out  1  input accepted when in_valid && in_ready.
REQ-010 in_img  in  NCH*PX_W  current-frame pixel, channel 0 in the LSBs.
REQ-011 in_bg  in  NCH*PX_W  background pixel, same packing.
REQ-012 in_sof / in_eof  in  1 each  first / last pixel of frame.
REQ-013 threshold  in  DIFF_W  foreground threshold.
REQ-014 out_valid  out  1; out_ready  in  1  output handshake.
REQ-015 out_bin  out  PX_W  all-ones if foreground, else zero.
REQ-016 out_fg / out_sof / out_eof  out  1 each  foreground flag and sideband aligned with out_bin.
REQ-017 fg_count  out  CNT_W  foreground pixel count of the last completed frame.
REQ-018 count_valid  out  1  one-cycle pulse when fg_count updates.

Function
REQ-019 SHALL compute diff = sum over channels of |img_c - bg_c|, unsigned, DIFF_W bits, no overflow.
REQ-020 SHALL set fg = (diff >= thr_q).
REQ-021 SHALL load thr_q from threshold on every accepted pixel with in_sof = 1; that pixel and the rest of its frame use the new value.
REQ-022 SHALL keep thr_q unchanged for accepted pixels with in_sof = 0.
REQ-023 Pipeline SHALL be two register stages: S1 holds per-channel absolute differences; S2 holds the sum/compare result, which drives the outputs.
REQ-024 SHALL define adv = !out_valid || out_ready and SHALL advance both stages only when adv = 1.
REQ-025 SHALL drive in_ready = adv combinationally.
REQ-026 Latency: pixel accepted at cycle N SHALL appear at the outputs at cycle N+2 when out_ready is held at 1.
REQ-027 Throughput SHALL be one pixel per cycle under continuous in_valid and out_ready.
REQ-028 While out_valid && !out_ready, all outputs SHALL hold stable; no data is lost or duplicated.
REQ-029 Frame accumulator SHALL update only on an output handshake: sof sets acc = fg; otherwise acc += fg; acc saturates at 2^CNT_W-1.
REQ-030 On an output handshake with out_eof = 1: fg_count <= the final acc value, including that pixel; count_valid = 1 for exactly the next cycle.
REQ-031 When one pixel has both sof and eof: fg_count = its fg, and count_valid SHALL pulse.
REQ-032 eof without a preceding sof SHALL still publish acc, accumulated since reset or the last eof.

Reset
REQ-033 On rst: out_valid, S1/S2 valid, out_bin, out_fg, out_sof, out_eof, acc, fg_count, count_valid and thr_q SHALL be 0.
REQ-034 Asserting rst mid-frame SHALL discard in-flight pixels and partial counts; the first post-reset frame SHALL count from 0.

Configuration
REQ-035 With macro FG_BG_UPDATE_EN defined: add output bg_upd  out  NCH*PX_W, aligned with out_bin.
REQ-036 For background pixels, bg_upd per channel = bg + ((img - bg) >>> ALPHA_SH), signed arithmetic, result in 0..2^PX_W-1.
REQ-037 For foreground pixels, bg_upd = bg unchanged.
REQ-038 Without FG_BG_UPDATE_EN: port bg_upd is absent and no update logic is built; all other behaviour is identical.

Structure
REQ-039 Shared package fg_pkg SHALL hold the DIFF_W derivation function, the parameter defaults and the ALPHA_SH default.
REQ-040 Sub-module px_absdiff (one PX_W absolute difference) SHALL be instantiated NCH times in S1.

Verification
REQ-041 PX_W=8, NCH=3, thr=30; img=(100,100,100), bg=(90,90,90) -> diff 30, out_bin=8'hFF two cycles later; bg=(91,90,90) -> out_bin=0.
REQ-042 10-pixel frame with 4 foreground pixels, out_ready=1 -> fg_count=4, single count_valid pulse one cycle after the eof handshake.
REQ-043 out_ready low 3 cycles mid-stream -> in_ready low, outputs stable; output sequence matches input order, no loss.
REQ-044 Threshold changed from 30 to 200 mid-frame -> no effect until the next sof pixel, which uses 200.
REQ-045 CNT_W=2, 5 foreground pixels in one frame -> fg_count=3 (saturated); rst asserted mid-frame -> all outputs 0, next frame counts from 0.
REQ-046 FG_BG_UPDATE_EN, ALPHA_SH=3: background pixel img=80, bg=160 -> bg_upd=150; foreground pixel -> bg_upd=bg.
